// File: rtl/multi_stream_stride_prefetch_ctrl.sv
// Multi-stream stride prefetcher: learns a signed block stride per address window and
// issues block prefetches round-robin on one shared AR port. States: IDLE | ARM (learning) | ACTIVE (issuing).
module multi_stream_stride_prefetch_ctrl #(
  parameter int ADDR_BITS    = 64,
  parameter int BLK_OFF_BITS = 6,
  parameter int NUM_STREAMS  = 4,
  parameter int PF_DEPTH     = 8,
  parameter int CONF_HITS    = 2,
  localparam int W  = ADDR_BITS - BLK_OFF_BITS,
  localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
  localparam int AW = $clog2(PF_DEPTH + 1),
  localparam int CW = $clog2(CONF_HITS + 2)
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             en,
  input  logic [NUM_STREAMS-1:0]           cfgEn,
  input  logic [NUM_STREAMS*ADDR_BITS-1:0] bar,
  input  logic [NUM_STREAMS*ADDR_BITS-1:0] limit,
  input  logic [NUM_STREAMS-1:0]           almostFull,
  input  logic [NUM_STREAMS-1:0]           consume,
  input  logic                             slaveValid,
  input  logic [ADDR_BITS-1:0]             slaveAddr,
  output logic                             slaveReady,
  output logic                             rangeHit,
  output logic [SW-1:0]                    hitStream,
  output logic [NUM_STREAMS-1:0]           flushN,
  output logic                             masterValid,
  output logic [ADDR_BITS-1:0]             masterAddr,
  output logic [SW-1:0]                    masterStream,
  input  logic                             masterReady
);
  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} streamState_t;

  streamState_t   state    [NUM_STREAMS];
  streamState_t   stateNxt [NUM_STREAMS];
  logic [W-1:0]   stride   [NUM_STREAMS];
  logic [W-1:0]   strideNxt[NUM_STREAMS];
  logic [W-1:0]   lastBlk  [NUM_STREAMS];
  logic [W-1:0]   lastNxt  [NUM_STREAMS];
  logic [W-1:0]   nextBlk  [NUM_STREAMS];
  logic [W-1:0]   nextNxt  [NUM_STREAMS];
  logic [AW-1:0]  aheadCnt [NUM_STREAMS];
  logic [AW-1:0]  aheadNxt [NUM_STREAMS];
  logic [CW-1:0]  confCnt  [NUM_STREAMS];
  logic [CW-1:0]  confNxt  [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] ovf, ovfNxt, inWin, elig, flushReq;

  logic [W-1:0]   barBlk   [NUM_STREAMS];
  logic [W-1:0]   limBlk   [NUM_STREAMS];
  logic [W-1:0]   delta    [NUM_STREAMS];
  logic [W:0]     blkStep  [NUM_STREAMS];
  logic [W:0]     nextStep [NUM_STREAMS];

  logic [W-1:0]   blk;
  logic [SW-1:0]  rrPtr, pick;
  logic           pickValid, issue;
  logic           unusedOff;

  assign blk        = slaveAddr[ADDR_BITS-1:BLK_OFF_BITS];
  assign slaveReady = en;
  assign unusedOff  = ^{bar, limit, slaveAddr[BLK_OFF_BITS-1:0]};

  // Bit W of the W+1-bit sums flags a carry/borrow out of the block space.
  for (genvar g = 0; g < NUM_STREAMS; g++) begin : gStream
    assign barBlk[g]   = bar[g*ADDR_BITS+BLK_OFF_BITS +: W];
    assign limBlk[g]   = limit[g*ADDR_BITS+BLK_OFF_BITS +: W];
    assign inWin[g]    = cfgEn[g] && (blk >= barBlk[g]) && (blk <= limBlk[g]);
    assign delta[g]    = blk - lastBlk[g];
    assign blkStep[g]  = {1'b0, blk} + {delta[g][W-1], delta[g]};
    assign nextStep[g] = {1'b0, nextBlk[g]} + {stride[g][W-1], stride[g]};
    assign elig[g]     = (state[g] == ACTIVE) && cfgEn[g] && !almostFull[g] && !ovf[g] &&
                         (aheadCnt[g] < AW'(PF_DEPTH)) &&
                         (nextBlk[g] >= barBlk[g]) && (nextBlk[g] <= limBlk[g]);
  end

  always_comb begin
    hitStream = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--)
      if (inWin[i]) hitStream = SW'(i);
    rangeHit = slaveValid && (|inWin);
  end

  always_comb begin
    pick      = '0;
    pickValid = 1'b0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (!pickValid && elig[(int'(rrPtr) + k) % NUM_STREAMS]) begin
        pickValid = 1'b1;
        pick      = SW'((int'(rrPtr) + k) % NUM_STREAMS);
      end
    end
    issue = en && !masterValid && pickValid;
  end

  always_comb begin
    logic inc, dec;
    logic [CW-1:0] confNew;
    flushReq = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      stateNxt[i]  = state[i];
      strideNxt[i] = stride[i];
      lastNxt[i]   = lastBlk[i];
      nextNxt[i]   = nextBlk[i];
      confNxt[i]   = confCnt[i];
      ovfNxt[i]    = ovf[i];
      inc          = issue && (pick == SW'(i));
      dec          = consume[i] && ((aheadCnt[i] != '0) || inc);
      aheadNxt[i]  = aheadCnt[i] + AW'(inc) - AW'(dec);
      confNew      = (delta[i] == stride[i]) ? confCnt[i] + CW'(1) : CW'(1);
      if (inc) begin
        nextNxt[i] = nextStep[i][W-1:0];
        ovfNxt[i]  = nextStep[i][W];
      end
      if (!cfgEn[i]) begin
        stateNxt[i] = IDLE;
        flushReq[i] = (state[i] == ACTIVE);
      end else if (rangeHit && (hitStream == SW'(i))) begin
        unique case (state[i])
          IDLE: begin
            stateNxt[i] = ARM;
            lastNxt[i]  = blk;
            confNxt[i]  = '0;
          end
          ARM: if (delta[i] != '0) begin
            strideNxt[i] = delta[i];
            lastNxt[i]   = blk;
            confNxt[i]   = confNew;
            if (confNew >= CW'(CONF_HITS)) begin
              stateNxt[i] = ACTIVE;
              nextNxt[i]  = blkStep[i][W-1:0];
              ovfNxt[i]   = blkStep[i][W];
              aheadNxt[i] = '0;
            end
          end
          ACTIVE: if (delta[i] == stride[i]) begin
            lastNxt[i] = blk;
          end else if (delta[i] != '0) begin
            flushReq[i]  = 1'b1;
            stateNxt[i]  = ARM;
            strideNxt[i] = delta[i];
            confNxt[i]   = CW'(1);
            aheadNxt[i]  = '0;
            lastNxt[i]   = blk;
          end
          default: stateNxt[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        state[i]    <= IDLE;
        stride[i]   <= '0;
        lastBlk[i]  <= '0;
        nextBlk[i]  <= '0;
        aheadCnt[i] <= '0;
        confCnt[i]  <= '0;
      end
      ovf          <= '0;
      flushN       <= '1;
      rrPtr        <= '0;
      masterValid  <= 1'b0;
      masterAddr   <= '0;
      masterStream <= '0;
    end else begin
      // A flush is a single-cycle pulse, so it is released even while frozen.
      flushN <= en ? ~flushReq : '1;
      if (en) begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
          state[i]    <= stateNxt[i];
          stride[i]   <= strideNxt[i];
          lastBlk[i]  <= lastNxt[i];
          nextBlk[i]  <= nextNxt[i];
          aheadCnt[i] <= aheadNxt[i];
          confCnt[i]  <= confNxt[i];
        end
        ovf <= ovfNxt;
        if (masterValid && masterReady) begin
          masterValid <= 1'b0;
        end else if (issue) begin
          masterValid  <= 1'b1;
          masterAddr   <= {nextBlk[pick], {BLK_OFF_BITS{1'b0}}};
          masterStream <= pick;
          rrPtr        <= (pick == SW'(NUM_STREAMS - 1)) ? '0 : pick + SW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_stream_stride_prefetch_ctrl.sv
// Bench for the multi-stream stride prefetcher: expected requests are queued as stimulus
// is applied and popped by a monitor at every accepted AR handshake.
module tb_multi_stream_stride_prefetch_ctrl;
  localparam int AB = 64;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            resetN, en, slaveValid, masterReady;
  logic [N-1:0]    cfgEn, almostFull, consume;
  logic [N*AB-1:0] bar, limit;
  logic [AB-1:0]   slaveAddr;
  logic            slaveReady, rangeHit, masterValid;
  logic [1:0]      hitStream, masterStream;
  logic [N-1:0]    flushN;
  logic [AB-1:0]   masterAddr;

  typedef struct { logic [AB-1:0] addr; logic [1:0] strm; } req_t;
  req_t expQ[$];
  int nChecks = 0;
  int nErrors = 0;
  int nHs = 0;

  multi_stream_stride_prefetch_ctrl #(
    .ADDR_BITS(64), .BLK_OFF_BITS(6), .NUM_STREAMS(4), .PF_DEPTH(8), .CONF_HITS(2)
  ) dut (
    .clk(clk), .resetN(resetN), .en(en), .cfgEn(cfgEn), .bar(bar), .limit(limit),
    .almostFull(almostFull), .consume(consume), .slaveValid(slaveValid),
    .slaveAddr(slaveAddr), .slaveReady(slaveReady), .rangeHit(rangeHit),
    .hitStream(hitStream), .flushN(flushN), .masterValid(masterValid),
    .masterAddr(masterAddr), .masterStream(masterStream), .masterReady(masterReady)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    req_t e;
    if (resetN && en && masterValid && masterReady) begin
      nHs++;
      nChecks++;
      if (expQ.size() == 0) begin
        nErrors++;
        $display("FAIL unexpected_req addr=%h stream=%0d required=none", masterAddr, masterStream);
      end else begin
        e = expQ.pop_front();
        if (masterAddr !== e.addr || masterStream !== e.strm) begin
          nErrors++;
          $display("FAIL req_order addr=%h stream=%0d required addr=%h stream=%0d",
                   masterAddr, masterStream, e.addr, e.strm);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic demand(logic [AB-1:0] a);
    slaveValid = 1'b1;
    slaveAddr  = a;
    tick();
    slaveValid = 1'b0;
  endtask

  task automatic push(logic [AB-1:0] a, logic [1:0] s);
    req_t r;
    r.addr = a;
    r.strm = s;
    expQ.push_back(r);
  endtask

  task automatic setWin(int i, logic [AB-1:0] b, logic [AB-1:0] l);
    bar[i*AB +: AB]   = b;
    limit[i*AB +: AB] = l;
  endtask

  task automatic test_reset();
    resetN = 1'b0; en = 1'b0; cfgEn = '0; almostFull = '0; consume = '0;
    slaveValid = 1'b0; slaveAddr = '0; masterReady = 1'b1; bar = '0; limit = '0;
    setWin(0, 64'h1000, 64'h1FFF);
    setWin(1, 64'h8000, 64'h8FFF);
    setWin(2, 64'h0000, 64'h1FFF);
    setWin(3, 64'h20000, 64'h20FFF);
    tick(3);
    nChecks++;
    if (masterValid !== 1'b0 || masterAddr !== '0 || masterStream !== 2'd0 || flushN !== 4'hF) begin
      nErrors++;
      $display("FAIL reset_state valid=%b addr=%h stream=%0d flushN=%b required 0/0/0/1111",
               masterValid, masterAddr, masterStream, flushN);
    end
    nChecks++;
    if (slaveReady !== 1'b0) begin
      nErrors++; $display("FAIL ready_en0 got=%b required=0", slaveReady);
    end
    resetN = 1'b1; en = 1'b1;
    tick();
    nChecks++;
    if (slaveReady !== 1'b1) begin
      nErrors++; $display("FAIL ready_en1 got=%b required=1", slaveReady);
    end
    slaveValid = 1'b1; slaveAddr = 64'h1040; #1;
    nChecks++;
    if (rangeHit !== 1'b0) begin
      nErrors++; $display("FAIL hit_disabled got=%b required=0", rangeHit);
    end
    cfgEn = 4'b0111; #1;
    nChecks++;
    if (rangeHit !== 1'b1 || hitStream !== 2'd0) begin
      nErrors++; $display("FAIL hit_lowest hit=%b stream=%0d required 1/0", rangeHit, hitStream);
    end
    slaveAddr = 64'h0800; #1;
    nChecks++;
    if (rangeHit !== 1'b1 || hitStream !== 2'd2) begin
      nErrors++; $display("FAIL hit_win2 hit=%b stream=%0d required 1/2", rangeHit, hitStream);
    end
    slaveAddr = 64'h8FC0; #1;
    nChecks++;
    if (rangeHit !== 1'b1 || hitStream !== 2'd1) begin
      nErrors++; $display("FAIL hit_win1 hit=%b stream=%0d required 1/1", rangeHit, hitStream);
    end
    slaveAddr = 64'h3000; #1;
    nChecks++;
    if (rangeHit !== 1'b0) begin
      nErrors++; $display("FAIL hit_outside got=%b required=0", rangeHit);
    end
    slaveValid = 1'b0; cfgEn = '0;
    tick();
  endtask

  task automatic test_train();
    int hs0;
    hs0 = nHs;
    cfgEn = 4'b0001;
    for (int j = 0; j < 8; j++) push(64'h10C0 + 64'h40 * j, 2'd0);
    demand(64'h1000);
    demand(64'h1040);
    tick(3);
    nChecks++;
    if (masterValid !== 1'b0) begin
      nErrors++; $display("FAIL early_issue valid=%b required=0", masterValid);
    end
    demand(64'h1080);
    tick(60);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 8) begin
      nErrors++; $display("FAIL train_depth issued=%0d pending=%0d required 8/0", nHs - hs0, expQ.size());
    end
  endtask

  task automatic test_consume();
    int hs0;
    hs0 = nHs;
    push(64'h12C0, 2'd0); push(64'h1300, 2'd0); push(64'h1340, 2'd0);
    for (int j = 0; j < 3; j++) begin
      consume = 4'b0001; tick(); consume = '0; tick(4);
    end
    tick(30);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 3) begin
      nErrors++; $display("FAIL consume_refill issued=%0d pending=%0d required 3/0", nHs - hs0, expQ.size());
    end
  endtask

  task automatic test_retrain();
    int hs0;
    hs0 = nHs;
    masterReady = 1'b0;
    consume = 4'b0001; tick(); consume = '0; tick(3);
    push(64'h1380, 2'd0);
    nChecks++;
    if (masterValid !== 1'b1 || masterAddr !== 64'h1380) begin
      nErrors++; $display("FAIL pending_req valid=%b addr=%h required 1/1380", masterValid, masterAddr);
    end
    demand(64'h1400);
    nChecks++;
    if (flushN !== 4'b1110) begin
      nErrors++; $display("FAIL flush_pulse flushN=%b required=1110", flushN);
    end
    tick();
    nChecks++;
    if (flushN !== 4'b1111) begin
      nErrors++; $display("FAIL flush_width flushN=%b required=1111", flushN);
    end
    nChecks++;
    if (masterValid !== 1'b1 || masterAddr !== 64'h1380 || masterStream !== 2'd0) begin
      nErrors++; $display("FAIL held_req valid=%b addr=%h required 1/1380", masterValid, masterAddr);
    end
    tick(3);
    masterReady = 1'b1;
    tick(40);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 1) begin
      nErrors++; $display("FAIL retrain_quiet issued=%0d pending=%0d required 1/0", nHs - hs0, expQ.size());
    end
  endtask

  task automatic test_neg_stride();
    int hs0;
    hs0 = nHs;
    for (int j = 0; j < 8; j++) push(64'h1E40 - 64'h40 * j, 2'd0);
    demand(64'h1F00);
    demand(64'h1EC0);
    demand(64'h1E80);
    tick(60);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 8) begin
      nErrors++; $display("FAIL neg_stride issued=%0d pending=%0d required 8/0", nHs - hs0, expQ.size());
    end
    cfgEn = 4'b0000; tick();
    nChecks++;
    if (flushN !== 4'b1110) begin
      nErrors++; $display("FAIL disable_flush flushN=%b required=1110", flushN);
    end
    cfgEn = 4'b0001; tick();
    nChecks++;
    if (flushN !== 4'b1111) begin
      nErrors++; $display("FAIL disable_flush_width flushN=%b required=1111", flushN);
    end
    hs0 = nHs;
    push(64'h1000, 2'd0);
    demand(64'h10C0);
    demand(64'h1080);
    demand(64'h1040);
    tick(40);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 1) begin
      nErrors++; $display("FAIL low_bound issued=%0d pending=%0d required 1/0", nHs - hs0, expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    int hs0;
    resetN = 1'b0; tick(); resetN = 1'b1; tick();
    cfgEn = 4'b0011; almostFull = 4'hF; masterReady = 1'b1;
    demand(64'h1000); demand(64'h1040); demand(64'h1080);
    demand(64'h8000); demand(64'h8080); demand(64'h8100);
    tick(3);
    nChecks++;
    if (masterValid !== 1'b0) begin
      nErrors++; $display("FAIL almost_full_block valid=%b required=0", masterValid);
    end
    hs0 = nHs;
    for (int j = 0; j < 8; j++) begin
      push(64'h10C0 + 64'h40 * j, 2'd0);
      push(64'h8180 + 64'h80 * j, 2'd1);
    end
    almostFull = '0;
    tick(60);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 16) begin
      nErrors++; $display("FAIL round_robin issued=%0d pending=%0d required 16/0", nHs - hs0, expQ.size());
    end
    hs0 = nHs;
    almostFull = 4'b0010;
    push(64'h12C0, 2'd0);
    consume = 4'b0011; tick(); consume = '0;
    tick(20);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 1) begin
      nErrors++; $display("FAIL af_only_s0 issued=%0d pending=%0d required 1/0", nHs - hs0, expQ.size());
    end
    hs0 = nHs;
    push(64'h8580, 2'd1);
    almostFull = '0;
    tick(20);
    nChecks++;
    if (expQ.size() != 0 || nHs - hs0 != 1) begin
      nErrors++; $display("FAIL af_release issued=%0d pending=%0d required 1/0", nHs - hs0, expQ.size());
    end
  endtask

  task automatic test_stall_reset();
    masterReady = 1'b0;
    consume = 4'b0001; tick(); consume = '0; tick(2);
    for (int j = 0; j < 5; j++) begin
      nChecks++;
      if (masterValid !== 1'b1 || masterAddr !== 64'h1300 || masterStream !== 2'd0) begin
        nErrors++; $display("FAIL stall_hold cyc=%0d valid=%b addr=%h required 1/1300", j, masterValid, masterAddr);
      end
      tick();
    end
    en = 1'b0; masterReady = 1'b1;
    tick(3);
    nChecks++;
    if (masterValid !== 1'b1 || masterAddr !== 64'h1300 || slaveReady !== 1'b0) begin
      nErrors++; $display("FAIL en_freeze valid=%b addr=%h ready=%b required 1/1300/0", masterValid, masterAddr, slaveReady);
    end
    #2 resetN = 1'b0;
    #1;
    nChecks++;
    if (masterValid !== 1'b0 || masterAddr !== '0) begin
      nErrors++; $display("FAIL async_reset valid=%b addr=%h required 0/0", masterValid, masterAddr);
    end
    tick(); resetN = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_train();
    test_consume();
    test_retrain();
    test_neg_stride();
    test_back_to_back();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
